// File: rtl/rv32_pkg.sv
// RV32I shared definitions: opcodes, instruction field positions and
// the decoded control bundle handed from ID to EX.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       is_load;
        logic       reg_write;
    } id_ctrl_t;

    function automatic logic opc_known(input logic [6:0] op);
        return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                          OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    endfunction

    function automatic id_ctrl_t decode(input logic [31:0] inst);
        id_ctrl_t c;
        c.opcode    = inst[OPC_LSB +: 7];
        c.funct3    = inst[F3_LSB +: 3];
        c.funct7    = inst[F7_LSB +: 7];
        c.rd        = inst[RD_LSB +: 5];
        c.rs1       = inst[RS1_LSB +: 5];
        c.rs2       = inst[RS2_LSB +: 5];
        c.is_load   = (c.opcode == OPC_LOAD);
        c.reg_write = opc_known(c.opcode) && (c.rd != 5'd0) &&
                      (c.opcode != OPC_STORE) && (c.opcode != OPC_BRANCH);
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: selects the I/S/B/U/J format from the
// opcode and sign-extends from inst[31]; OP and unknown opcodes give 0.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);
    import rv32_pkg::*;

    logic [6:0]  opc;
    logic [31:0] imm32;

    assign opc = inst[OPC_LSB +: 7];

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            (opc == OPC_LOAD) || (opc == OPC_OP_IMM) || (opc == OPC_JALR):
                imm32 = {{20{inst[31]}}, inst[31:20]};
            (opc == OPC_STORE):
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            (opc == OPC_BRANCH):
                imm32 = {{19{inst[31]}}, inst[31], inst[7],
                         inst[30:25], inst[11:8], 1'b0};
            (opc == OPC_LUI) || (opc == OPC_AUIPC):
                imm32 = {inst[31:12], 12'h000};
            (opc == OPC_JAL):
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                         inst[20], inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives register-file read addresses, registers the
// decoded fields alongside the read data, and inserts load-use bubbles.
module decode_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = rv32_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            fetch_stall,
    output logic [4:0]      reg1_addr,
    output logic [4:0]      reg2_addr,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [XLEN-1:0] id_imm,
    output logic            id_is_load,
    output logic            id_reg_write
);
    import rv32_pkg::*;

    id_ctrl_t        ctrl_q;
    id_ctrl_t        dec;
    id_ctrl_t        ctrl_d;
    logic [31:0]     dec_inst;
    logic [XLEN-1:0] dec_imm;
    logic            hold;
    logic            load_use;
    logic            accept;

    assign hold = ex_stall && !flush;

    // A flush loads the NOP encoding so the killed slot decodes as harmless.
    assign dec_inst = flush ? NOP_INST : if_inst;
    assign dec      = decode(dec_inst);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (dec_inst),
        .imm  (dec_imm)
    );

    always_comb begin
        load_use = 1'b0;
        if (!hold && !flush && id_valid && ctrl_q.is_load &&
            (ctrl_q.rd != 5'd0) && if_valid) begin
            load_use = (uses_rs1(dec.opcode) && (dec.rs1 == ctrl_q.rd)) ||
                       (uses_rs2(dec.opcode) && (dec.rs2 == ctrl_q.rd));
        end
    end

    assign accept = !flush && if_valid && !load_use;

    always_comb begin
        ctrl_d         = dec;
        ctrl_d.is_load = dec.is_load && accept;
    end

    assign fetch_stall = rst_n && !flush && (ex_stall || load_use);

    // While held, re-read the held sources so bypassed writebacks land.
    assign reg1_addr = hold ? ctrl_q.rs1 : if_inst[RS1_LSB +: 5];
    assign reg2_addr = hold ? ctrl_q.rs2 : if_inst[RS2_LSB +: 5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            ctrl_q   <= '0;
            id_imm   <= '0;
        end else if (!hold) begin
            id_valid <= accept;
            id_pc    <= if_pc;
            ctrl_q   <= ctrl_d;
            id_imm   <= dec_imm;
        end
    end

    assign id_opcode    = ctrl_q.opcode;
    assign id_funct3    = ctrl_q.funct3;
    assign id_funct7    = ctrl_q.funct7;
    assign id_rd        = ctrl_q.rd;
    assign id_rs1       = ctrl_q.rs1;
    assign id_rs2       = ctrl_q.rs2;
    assign id_is_load   = ctrl_q.is_load;
    assign id_reg_write = ctrl_q.reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vectors, hand-written
// hazard/stall/flush/reset sequences, then random traffic vs a reference model.
module tb_decode_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        ex_stall;
    logic        flush;
    logic        fetch_stall;
    logic [4:0]  reg1_addr;
    logic [4:0]  reg2_addr;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_imm;
    logic        id_is_load;
    logic        id_reg_write;

    decode_stage #(.XLEN(32), .NOP_INST(32'h00000013)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .fetch_stall  (fetch_stall),
        .reg1_addr    (reg1_addr),
        .reg2_addr    (reg2_addr),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_funct7    (id_funct7),
        .id_rd        (id_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_imm       (id_imm),
        .id_is_load   (id_is_load),
        .id_reg_write (id_reg_write)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_ADD  = 32'h002101B3;
    localparam logic [31:0] I_SW   = 32'hFE20AE23;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic s, input logic f);
        if_valid = v;
        if_inst  = i;
        if_pc    = p;
        ex_stall = s;
        flush    = f;
    endtask

    function automatic logic ref_uses1(input logic [6:0] op);
        return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
    endfunction

    function automatic logic ref_uses2(input logic [6:0] op);
        return op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP;
    endfunction

    function automatic logic ref_rw(input logic [31:0] i);
        logic [6:0] op;
        logic known;
        op = i[6:0];
        known = op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL ||
                op == OPC_JALR || op == OPC_BRANCH || op == OPC_LOAD ||
                op == OPC_STORE || op == OPC_OP_IMM || op == OPC_OP;
        return known && i[11:7] != 0 && op != OPC_STORE && op != OPC_BRANCH;
    endfunction

    // Immediate value built arithmetically from the format definitions.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [6:0] op;
        int v;
        op = i[6:0];
        v = 0;
        if (op == OPC_LOAD || op == OPC_OP_IMM || op == OPC_JALR)
            v = int'(i[31:20]) - (i[31] ? 4096 : 0);
        else if (op == OPC_STORE)
            v = int'({i[31:25], i[11:7]}) - (i[31] ? 4096 : 0);
        else if (op == OPC_BRANCH)
            v = 4096 * int'(i[31]) + 2048 * int'(i[7]) + 32 * int'(i[30:25])
                + 2 * int'(i[11:8]) - (i[31] ? 8192 : 0);
        else if (op == OPC_JAL)
            v = (1 << 20) * int'(i[31]) + 4096 * int'(i[19:12])
                + 2048 * int'(i[20]) + 2 * int'(i[30:21])
                - (i[31] ? (1 << 21) : 0);
        else if (op == OPC_LUI || op == OPC_AUIPC)
            return {i[31:12], 12'h000};
        return 32'(v);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        logic [31:0] i;
        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, 7'h0B};
        i = $urandom;
        i[6:0]   = ops[$urandom_range(0, 9)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    task automatic chk_id(input string tag, input logic [31:0] i,
                          input logic [31:0] p);
        chk({tag, "_pc"}, id_pc, p);
        chk({tag, "_opcode"}, 32'(id_opcode), 32'(i[6:0]));
        chk({tag, "_funct3"}, 32'(id_funct3), 32'(i[14:12]));
        chk({tag, "_funct7"}, 32'(id_funct7), 32'(i[31:25]));
        chk({tag, "_rd"}, 32'(id_rd), 32'(i[11:7]));
        chk({tag, "_rs1"}, 32'(id_rs1), 32'(i[19:15]));
        chk({tag, "_rs2"}, 32'(id_rs2), 32'(i[24:20]));
        chk({tag, "_imm"}, id_imm, ref_imm(i));
        chk({tag, "_reg_write"}, 32'(id_reg_write), 32'(ref_rw(i)));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pc"}, id_pc, 32'h0);
        chk({tag, "_opcode"}, 32'(id_opcode), 32'h0);
        chk({tag, "_funct3"}, 32'(id_funct3), 32'h0);
        chk({tag, "_funct7"}, 32'(id_funct7), 32'h0);
        chk({tag, "_rd"}, 32'(id_rd), 32'h0);
        chk({tag, "_rs1"}, 32'(id_rs1), 32'h0);
        chk({tag, "_rs2"}, 32'(id_rs2), 32'h0);
        chk({tag, "_imm"}, id_imm, 32'h0);
        chk({tag, "_is_load"}, 32'(id_is_load), 32'h0);
        chk({tag, "_reg_write"}, 32'(id_reg_write), 32'h0);
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rw;
        logic        ld;
    } vec_t;

    vec_t tbl [12];

    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_ld;
    logic        m_zero;
    logic        haz;
    logic        exp_fs;
    logic        exp_fs_prev;
    logic [4:0]  m_rd;

    initial begin
        tbl[0]  = '{32'h00500093, 32'h00000005, 5'd1,  5'd0, 5'd5, 1'b1, 1'b0};
        tbl[1]  = '{32'h0000A103, 32'h00000000, 5'd2,  5'd1, 5'd0, 1'b1, 1'b1};
        tbl[2]  = '{32'hFE20AE23, 32'hFFFFFFFC, 5'd28, 5'd1, 5'd2, 1'b0, 1'b0};
        tbl[3]  = '{32'h002101B3, 32'h00000000, 5'd3,  5'd2, 5'd2, 1'b1, 1'b0};
        tbl[4]  = '{32'h123452B7, 32'h12345000, 5'd5,  5'd8, 5'd3, 1'b1, 1'b0};
        tbl[5]  = '{32'hFFFFF017, 32'hFFFFF000, 5'd0,  5'd31, 5'd31, 1'b0, 1'b0};
        tbl[6]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 5'd1,  5'd31, 5'd29, 1'b1, 1'b0};
        tbl[7]  = '{32'h00208463, 32'h00000008, 5'd8,  5'd1, 5'd2, 1'b0, 1'b0};
        tbl[8]  = '{32'hFE209CE3, 32'hFFFFFFF8, 5'd25, 5'd1, 5'd2, 1'b0, 1'b0};
        tbl[9]  = '{32'h00008067, 32'h00000000, 5'd0,  5'd1, 5'd0, 1'b0, 1'b0};
        tbl[10] = '{32'hFFFFFFFF, 32'h00000000, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0};
        tbl[11] = '{32'hFFF08093, 32'hFFFFFFFF, 5'd1,  5'd1, 5'd31, 1'b1, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_valid", 32'(id_valid), 32'h0);
        chk_zero("reset");
        chk("reset_fetch_stall", 32'(fetch_stall), 32'h0);
        ex_stall = 1'b1;
        #1;
        chk("reset_fetch_stall_exst", 32'(fetch_stall), 32'h0);
        ex_stall = 1'b0;
        rst_n = 1'b1;

        // addi x1,x0,5
        drive(1'b1, I_ADDI, 32'h100, 1'b0, 1'b0);
        #1;
        chk("addi_reg1_addr", 32'(reg1_addr), 32'h0);
        chk("addi_fetch_stall", 32'(fetch_stall), 32'h0);
        tick();
        chk("addi_valid", 32'(id_valid), 32'h1);
        chk("addi_rd", 32'(id_rd), 32'h1);
        chk("addi_rs1", 32'(id_rs1), 32'h0);
        chk("addi_imm", id_imm, 32'h5);
        chk("addi_reg_write", 32'(id_reg_write), 32'h1);

        // load-use: lw x2 then add x3,x2,x2
        drive(1'b1, I_LW, 32'h104, 1'b0, 1'b0);
        tick();
        chk("lu_lw_is_load", 32'(id_is_load), 32'h1);
        drive(1'b1, I_ADD, 32'h108, 1'b0, 1'b0);
        #1;
        chk("lu_fetch_stall_hi", 32'(fetch_stall), 32'h1);
        tick();
        chk("lu_bubble_valid", 32'(id_valid), 32'h0);
        chk("lu_bubble_is_load", 32'(id_is_load), 32'h0);
        chk("lu_fetch_stall_lo", 32'(fetch_stall), 32'h0);
        tick();
        chk("lu_add_valid", 32'(id_valid), 32'h1);
        chk("lu_add_rs1", 32'(id_rs1), 32'h2);
        chk("lu_add_rs2", 32'(id_rs2), 32'h2);
        chk("lu_add_pc", id_pc, 32'h108);

        // sw x2,-4(x1) then add: no bubble
        drive(1'b1, I_SW, 32'h10C, 1'b0, 1'b0);
        tick();
        chk("sw_imm", id_imm, 32'hFFFFFFFC);
        chk("sw_reg_write", 32'(id_reg_write), 32'h0);
        chk("sw_rs2", 32'(id_rs2), 32'h2);
        drive(1'b1, I_ADD, 32'h110, 1'b0, 1'b0);
        #1;
        chk("sw_add_fetch_stall", 32'(fetch_stall), 32'h0);
        tick();
        chk("sw_add_valid", 32'(id_valid), 32'h1);
        chk("sw_add_pc", id_pc, 32'h110);

        // ex_stall for 3 cycles with add in ID
        drive(1'b1, I_ADDI, 32'h114, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("exst_fetch_stall", 32'(fetch_stall), 32'h1);
            chk("exst_reg1_addr", 32'(reg1_addr), 32'h2);
            chk("exst_reg2_addr", 32'(reg2_addr), 32'h2);
            tick();
            chk("exst_valid", 32'(id_valid), 32'h1);
            chk("exst_rd", 32'(id_rd), 32'h3);
            chk("exst_pc", id_pc, 32'h110);
        end
        ex_stall = 1'b0;
        #1;
        chk("exst_release_fs", 32'(fetch_stall), 32'h0);
        chk("exst_release_reg1", 32'(reg1_addr), 32'h0);
        tick();
        chk("exst_accept_pc", id_pc, 32'h114);
        chk("exst_accept_rd", 32'(id_rd), 32'h1);
        chk("exst_accept_valid", 32'(id_valid), 32'h1);

        // flush wins over ex_stall
        drive(1'b1, I_ADD, 32'h118, 1'b1, 1'b1);
        #1;
        chk("flush_fetch_stall", 32'(fetch_stall), 32'h0);
        tick();
        chk("flush_valid", 32'(id_valid), 32'h0);
        chk("flush_is_load", 32'(id_is_load), 32'h0);

        // reset mid-stream with a hazard pending
        drive(1'b1, I_LW, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, I_ADD, 32'h204, 1'b0, 1'b0);
        #1;
        chk("rst_mid_hazard_fs", 32'(fetch_stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_fs", 32'(fetch_stall), 32'h0);
        tick();
        chk("rst_mid_valid", 32'(id_valid), 32'h0);
        chk("rst_mid_is_load", 32'(id_is_load), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_rel_fs", 32'(fetch_stall), 32'h0);
        chk_zero("rst_rel");

        // directed vector table, idle cycle between entries
        for (int v = 0; v < 12; v++) begin
            drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
            tick();
            drive(1'b1, tbl[v].inst, 32'h400 + 32'(v) * 4, 1'b0, 1'b0);
            #1;
            chk("tbl_reg1_addr", 32'(reg1_addr), 32'(tbl[v].rs1));
            chk("tbl_reg2_addr", 32'(reg2_addr), 32'(tbl[v].rs2));
            tick();
            chk("tbl_valid", 32'(id_valid), 32'h1);
            chk("tbl_imm", id_imm, tbl[v].imm);
            chk("tbl_rd", 32'(id_rd), 32'(tbl[v].rd));
            chk("tbl_rs1", 32'(id_rs1), 32'(tbl[v].rs1));
            chk("tbl_rs2", 32'(id_rs2), 32'(tbl[v].rs2));
            chk("tbl_reg_write", 32'(id_reg_write), 32'(tbl[v].rw));
            chk("tbl_is_load", 32'(id_is_load), 32'(tbl[v].ld));
            chk("tbl_pc", id_pc, 32'h400 + 32'(v) * 4);
        end

        // random traffic against the reference model
        rst_n = 1'b0;
        drive(1'b0, NOP_INST, 32'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_ld = 1'b0;
        m_zero = 1'b1;
        m_inst = NOP_INST;
        m_pc = 32'h0;
        exp_fs_prev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!exp_fs_prev) begin
                if_valid = ($urandom_range(0, 3) != 0);
                if_inst  = rand_inst();
                if_pc    = $urandom & 32'hFFFFFFFC;
            end
            ex_stall = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            rst_n    = ($urandom_range(0, 99) != 0);
            #1;
            m_rd = m_inst[11:7];
            haz = m_valid && m_ld && m_rd != 0 && if_valid &&
                  ((ref_uses1(if_inst[6:0]) && if_inst[19:15] == m_rd) ||
                   (ref_uses2(if_inst[6:0]) && if_inst[24:20] == m_rd));
            exp_fs = rst_n && !flush && (ex_stall || haz);
            chk("rnd_fetch_stall", 32'(fetch_stall), 32'(exp_fs));
            if (rst_n) begin
                if (ex_stall && !flush) begin
                    if (m_valid) begin
                        chk("rnd_hold_reg1", 32'(reg1_addr), 32'(m_inst[19:15]));
                        chk("rnd_hold_reg2", 32'(reg2_addr), 32'(m_inst[24:20]));
                    end
                end else begin
                    chk("rnd_reg1_addr", 32'(reg1_addr), 32'(if_inst[19:15]));
                    chk("rnd_reg2_addr", 32'(reg2_addr), 32'(if_inst[24:20]));
                end
            end
            if (!rst_n) begin
                m_valid = 1'b0;
                m_ld = 1'b0;
                m_zero = 1'b1;
            end else if (flush) begin
                m_valid = 1'b0;
                m_ld = 1'b0;
                m_zero = 1'b0;
            end else if (!ex_stall) begin
                m_valid = if_valid && !haz;
                m_zero = 1'b0;
                if (m_valid) begin
                    m_inst = if_inst;
                    m_pc = if_pc;
                end
                m_ld = m_valid && if_inst[6:0] == OPC_LOAD;
            end
            exp_fs_prev = exp_fs;
            tick();
            chk("rnd_valid", 32'(id_valid), 32'(m_valid));
            chk("rnd_is_load", 32'(id_is_load), 32'(m_ld));
            if (m_valid)
                chk_id("rnd", m_inst, m_pc);
            else if (m_zero)
                chk_zero("rnd_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
